// File: rtl/serial_adder_pkg.sv
// Shared encodings for the bit-serial adder tile: FSM states, uio pin indices, output-enable mask.
// Pure declarations, no timing or flow control of its own.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;
    localparam int BUSY   = 4;
    localparam int DONE   = 5;
    localparam int CARRY  = 6;
    localparam int SUM    = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_serial_adder_fa_cell.sv
// One-bit full adder, purely combinational (zero latency).
// No flow control; the caller decides when its outputs are consumed.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial WIDTH-bit adder tile: one bit per enabled clock, LSB first, done WIDTH edges after start.
// ena low freezes all state; loads and start are ignored while a run is shifting.
module tt_um_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             fa_s;
    logic             fa_cout;
    logic             sum_bit;
    logic             unused_ok;

    fa_cell u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign count_d = count_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (uio_in[LOAD_A]) op_a_q <= ui_in[WIDTH-1:0];
                    if (uio_in[LOAD_B]) op_b_q <= ui_in[WIDTH-1:0];
                    // Start snapshots the operands held before this edge; a same-edge load waits for the next run.
                    if (uio_in[START]) begin
                        sh_a_q   <= op_a_q;
                        sh_b_q   <= op_b_q;
                        carry_q  <= 1'b0;
                        count_q  <= '0;
                        result_q <= '0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    carry_q  <= fa_cout;
                    sh_a_q   <= sh_a_q >> 1;
                    sh_b_q   <= sh_b_q >> 1;
                    result_q <= {fa_s, result_q[WIDTH-1:1]};
                    count_q  <= count_d;
                    if (count_d == CW'(WIDTH)) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sum_bit = (state_q == S_SHIFT) & fa_s;

    always_comb begin
        uo_out               = '0;
        uo_out[WIDTH-1:0]    = result_q;
        uio_out              = '0;
        uio_out[BUSY]        = (state_q == S_SHIFT);
        uio_out[DONE]        = (state_q == S_DONE);
        uio_out[CARRY]       = carry_q;
        uio_out[SUM]         = sum_bit;
    end

    assign uio_oe = UIO_OE_VAL;

    assign unused_ok = &{1'b0, ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Scoreboard bench for the serial adder tile: expected sums queued at start, checked at done.
module tb_tt_um_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         both;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       exp_q[$];
    logic       bit_q[$];
    logic [7:0] mdl_a;
    logic [7:0] mdl_b;

    vec_t tbl[5] = '{
        '{8'h5A, 8'h33, 1'b0},
        '{8'hFF, 8'h01, 1'b0},
        '{8'h80, 8'h80, 1'b0},
        '{8'h7F, 8'h7F, 1'b1},
        '{8'hC3, 8'hA7, 1'b0}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        ui_in  = a;
        uio_in = 8'h01;
        tick();
        mdl_a  = a;
        ui_in  = b;
        uio_in = 8'h02;
        tick();
        mdl_b  = b;
        uio_in = 8'h00;
    endtask

    task automatic push_run();
        logic [8:0] full;
        exp_t       e;
        full   = {1'b0, mdl_a} + {1'b0, mdl_b};
        e.sum  = full[7:0];
        e.cout = full[8];
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) bit_q.push_back(full[i]);
    endtask

    task automatic start_run();
        push_run();
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (2) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            tick();
        end
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_uo_out: got %h want 00", uo_out);
        end
        n_cmp++;
        if (uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_uio_out: got %h want 00", uio_out);
        end
        n_cmp++;
        if (uio_oe !== 8'hF0) begin
            n_bad++;
            $display("FAIL reset_uio_oe: got %h want f0", uio_oe);
        end
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b1;
        mdl_a  = 8'h00;
        mdl_b  = 8'h00;
        tick();
    endtask

    task automatic test_add_table();
        for (int t = 0; t < 5; t++) begin
            int   cyc;
            logic eb;
            exp_t e;
            if (tbl[t].both) begin
                ui_in  = tbl[t].a;
                uio_in = 8'h03;
                tick();
                mdl_a  = tbl[t].a;
                mdl_b  = tbl[t].a;
                uio_in = 8'h00;
            end else begin
                load_ops(tbl[t].a, tbl[t].b);
            end
            start_run();
            cyc = 0;
            while (!uio_out[5] && cyc < 40) begin
                eb = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
                n_cmp++;
                if (uio_out[4] !== 1'b1 || uio_out[7] !== eb) begin
                    n_bad++;
                    $display("FAIL add_sum_bit[%0d] vec %0d: busy %b sum_bit %b want busy 1 sum_bit %b",
                             cyc, t, uio_out[4], uio_out[7], eb);
                end
                tick();
                cyc++;
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc !== 8) begin
                n_bad++;
                $display("FAIL add_latency vec %0d: done after %0d edges want 8", t, cyc);
            end
            n_cmp++;
            if (uo_out !== e.sum || uio_out[6] !== e.cout || uio_out[7] !== 1'b0) begin
                n_bad++;
                $display("FAIL add_result vec %0d: sum %h carry %b sum_bit %b want sum %h carry %b sum_bit 0",
                         t, uo_out, uio_out[6], uio_out[7], e.sum, e.cout);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int   cyc;
        exp_t e;
        load_ops(8'h5A, 8'h33);
        start_run();
        tick();
        tick();
        ui_in  = 8'h00;
        uio_in = 8'h05;
        tick();
        uio_in = 8'h00;
        cyc = 3;
        while (!uio_out[5] && cyc < 40) begin
            tick();
            cyc++;
        end
        bit_q.delete();
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 8 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL ignored_during_shift: edges %0d sum %h carry %b want 8 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
        start_run();
        cyc = 0;
        while (!uio_out[5] && cyc < 40) begin
            tick();
            cyc++;
        end
        bit_q.delete();
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 8 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL ignored_rerun: edges %0d sum %h carry %b want 8 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
    endtask

    task automatic test_reset_midop();
        int   cyc;
        exp_t e;
        load_ops(8'h5A, 8'h33);
        start_run();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b0 || uo_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midop_reset: busy %b done %b uo %h want 0 0 00",
                     uio_out[4], uio_out[5], uo_out);
        end
        rst_n = 1'b1;
        exp_q.delete();
        bit_q.delete();
        mdl_a = 8'h00;
        mdl_b = 8'h00;
        start_run();
        cyc = 0;
        while (!uio_out[5] && cyc < 40) begin
            tick();
            cyc++;
        end
        bit_q.delete();
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 8 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL midop_rerun: edges %0d sum %h carry %b want 8 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
    endtask

    task automatic test_enable_stall();
        int   cyc;
        exp_t e;
        load_ops(8'h5A, 8'h33);
        start_run();
        tick();
        tick();
        ena = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (uio_out[4] !== 1'b1 || uio_out[5] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold: busy %b done %b want 1 0", uio_out[4], uio_out[5]);
            end
        end
        ena = 1'b1;
        cyc = 5;
        while (!uio_out[5] && cyc < 40) begin
            tick();
            cyc++;
        end
        bit_q.delete();
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 11 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL stall_result: edges %0d sum %h carry %b want 11 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        load_ops(8'h12, 8'h34);
        push_run();
        uio_in = 8'h04;
        tick();
        cyc = 0;
        while (!uio_out[5] && cyc < 40) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 8 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL b2b_first: edges %0d sum %h carry %b want 8 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
        bit_q.delete();
        push_run();
        tick();
        n_cmp++;
        if (uio_out[4] !== 1'b1 || uio_out[5] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_restart: busy %b done %b want 1 0", uio_out[4], uio_out[5]);
        end
        uio_in = 8'h00;
        cyc = 9;
        while (!uio_out[5] && cyc < 60) begin
            tick();
            cyc++;
        end
        bit_q.delete();
        e = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 17 || uo_out !== e.sum || uio_out[6] !== e.cout) begin
            n_bad++;
            $display("FAIL b2b_second: edges %0d sum %h carry %b want 17 %h %b",
                     cyc, uo_out, uio_out[6], e.sum, e.cout);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        mdl_a  = 8'h00;
        mdl_b  = 8'h00;
        test_reset();
        test_add_table();
        test_ignored_inputs();
        test_reset_midop();
        test_enable_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_adder.md
Name: tt_um_serial_adder

Overview:
- Bit-serial WIDTH-bit adder. It is the sequential stage that feeds the team's one-bit full-adder cell, one operand bit pair per clock, LSB first.
- Carry is held in a flop between bit times.
- Operands are loaded byte-wise over ui_in. The result is presented on uo_out. Status and serial taps appear on the upper uio pins.
- It is a standalone TinyTapeout user tile.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..8. Unused upper uo_out bits are driven 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- ena  input  1  clock enable; when low all state holds
- ui_in  input  8  operand data byte; bits [WIDTH-1:0] are used
- uio_in  input  8  [0]=load_a, [1]=load_b, [2]=start; [7:3] are ignored
- uo_out  output  8  {zeros, result[WIDTH-1:0]}
- uio_out  output  8  [3:0]=0, [4]=busy, [5]=done, [6]=carry, [7]=sum_bit
- uio_oe  output  8  constant 8'hF0

Behaviour:
- Reset: the clock is clk and the reset is rst_n, synchronous and active-low, sampled on the rising clk edge. While rst_n=0 at an edge:
  - state=IDLE
  - op_a, op_b, sh_a, sh_b, result, carry, count all =0
  - uo_out=0, uio_out=0; uio_oe stays 8'hF0
- ena=0 freezes every register, including the FSM and count. Outputs hold. Reset still takes priority over ena.
- Registers:
  - op_a and op_b hold the loaded operands.
  - sh_a and sh_b are working shift copies.
  - result is the sum shift register.
  - carry is 1 bit.
  - count is a bit counter, $clog2(WIDTH+1) bits wide.
- Loads: in IDLE or DONE, load_a=1 captures ui_in[WIDTH-1:0] into op_a, and load_b=1 does the same into op_b.
  - load_a and load_b may be asserted together; both then capture the same byte.
  - Loads are ignored in SHIFT.
- States:
  - IDLE: when start=1, copy op_a to sh_a and op_b to sh_b, clear carry, count and result, and go to SHIFT. Otherwise stay.
  - SHIFT: each enabled edge does the following, then stays in SHIFT unless count reaches WIDTH, in which case it goes to DONE:
    - s = sh_a[0]^sh_b[0]^carry; carry <= majority(sh_a[0], sh_b[0], carry)
    - sh_a, sh_b shift right by one
    - result <= {s, result[WIDTH-1:1]}
    - count <= count+1
  - SHIFT ignores start.
  - DONE: result and the final carry are held. start=1 behaves exactly as in IDLE and goes to SHIFT. Otherwise stay.
- Start and load in the same edge: start copies the op_a/op_b values held before that edge, and the load updates op_* in parallel. The new operand takes effect at the next start.
- start is level-sampled. Holding start high in DONE re-runs the addition back-to-back with one DONE cycle between runs.
- Latency: start is sampled at edge N.
  - Bit shifts occur at edges N+1..N+WIDTH.
  - done=1 from edge N+WIDTH onward.
  - busy=1 after edge N through edge N+WIDTH-1, i.e. exactly when state=SHIFT.
- Outputs:
  - busy = (state==SHIFT); done = (state==DONE).
  - carry = carry flop. In DONE this is the carry-out of the whole addition.
  - sum_bit = the combinational s for the current bit while in SHIFT, else 0.
  - uo_out = zero-extended result.
- Wrap: the sum is modulo 2^WIDTH, and the overflow appears only on carry.
- Reset mid-operation: the run is abandoned and all state clears as above. No partial result survives.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; code 3 recovers to IDLE
  - the uio bit-index constants: LOAD_A=0, LOAD_B=1, START=2, BUSY=4, DONE=5, CARRY=6, SUM=7
  - UIO_OE_VAL=8'hF0
- One sub-module, fa_cell: a combinational one-bit full adder with inputs a, b, cin and outputs s, cout. It is instanced once for the serial bit datapath.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random ui_in/uio_in -> uo_out=8'h00; uio_out=8'h00; uio_oe=8'hF0.
- Basic add: load_a with 0x5A, load_b with 0x33, then start.
  - sum_bit over the 8 shift cycles is 1,0,1,1,0,0,0,1.
  - After edge N+8: done=1, uo_out=8'h8D, carry=0.
- Overflow: 0xFF + 0x01 -> uo_out=8'h00, carry=1, done=1 after edge N+8. Then 0x80 + 0x80 -> uo_out=8'h00, carry=1.
- Ignored inputs: during SHIFT, pulse load_a with 0x00 and pulse start -> the result is unaffected (0x5A+0x33=0x8D). A following start in DONE, with no new load, again gives 0x8D.
- Reset mid-op: assert rst_n=0 after the 4th shift edge -> next cycle busy=0, done=0, uo_out=0. A start with no loads then gives 0x00+0x00 = 0x00, carry=0.
- Enable stall: drop ena for 3 cycles during SHIFT -> busy stays 1, done rises at edge N+11, result is still correct (0x8D).
